// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state encoding,
// Sysbus read tag fields and the line geometry helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } fetch_state_e;

  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
  localparam int         SYSBUS_KIND_W = 5;

  // Read-from-memory tag at the default 13-bit tag width.
  localparam logic [12:0] FETCH_RD_TAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

  function automatic int fetch_beats(input int line_bytes, input int bus_data_width);
    return (line_bytes * 8) / bus_data_width;
  endfunction

  function automatic int fetch_offw(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch unit boundary: decoder valid/ready handshake plus the Sysbus read-burst signals.
interface fetch_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int ILEN           = 32
);
  logic                      instr_valid;
  logic                      instr_ready;
  logic [ILEN-1:0]           instr;
  logic [63:0]               instr_pc;
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  modport master (
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  modport slave (
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

// File: rtl/fetch_line_buf.sv
// One-line instruction buffer: beat-wide write port, instruction-slot read mux,
// and the line tag/valid registers.
module fetch_line_buf #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BEATS          = 8,
  parameter int ILEN           = 32,
  parameter int TAGW           = 58,
  parameter int BEAT_W         = 3,
  parameter int SLOT_W         = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [BEAT_W-1:0]         wbeat,
  input  logic [BUS_DATA_WIDTH-1:0] wdata,
  input  logic                      set_valid,
  input  logic [TAGW-1:0]           set_tag,
  input  logic                      clr_valid,
  input  logic [SLOT_W-1:0]         slot,
  output logic [ILEN-1:0]           rdata,
  output logic                      line_valid,
  output logic [TAGW-1:0]           line_tag
);
  localparam int NSLOT = (BEATS * BUS_DATA_WIDTH) / ILEN;

  logic [BEATS-1:0][BUS_DATA_WIDTH-1:0] line_r;
  logic [NSLOT-1:0][ILEN-1:0]           slots_s;
  logic                                 valid_r;
  logic [TAGW-1:0]                      tag_r;

  // Line storage; beat k lands at the k-th BUS_DATA_WIDTH slice (little-endian).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_r <= '0;
    end else if (we) begin
      line_r[wbeat] <= wdata;
    end
  end

  // Tag/valid: set on the final beat wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= 1'b0;
      tag_r   <= '0;
    end else if (set_valid) begin
      valid_r <= 1'b1;
      tag_r   <= set_tag;
    end else if (clr_valid) begin
      valid_r <= 1'b0;
    end
  end

  assign slots_s    = line_r;
  assign rdata      = slots_s[slot];
  assign line_valid = valid_r;
  assign line_tag   = tag_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetch PC, one-line buffer, Sysbus read-burst refill and decoder issue.
// Optional FETCH_PERF_CNT_EN adds saturating perf_hits/perf_misses counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BYTES     = 64,
  parameter int ILEN           = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] entry,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  fetch_if.master     fif
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);
  localparam int BEATS  = fetch_beats(LINE_BYTES, BUS_DATA_WIDTH);
  localparam int OFFW   = fetch_offw(LINE_BYTES);
  localparam int TAGW   = 64 - OFFW;
  localparam int SLOT_W = OFFW - 2;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BUS_TAG_WIDTH-1:0] RD_TAG =
    {SYSBUS_READ, SYSBUS_MEMORY, {(BUS_TAG_WIDTH - SYSBUS_KIND_W){1'b0}}};

  fetch_state_e      state_r;
  fetch_state_e      state_nxt_s;
  logic [63:0]       pc_r;
  logic [TAGW-1:0]   req_tag_r;
  logic [BEAT_W-1:0] beat_r;
  logic              hit_s;
  logic              fire_s;
  logic              miss_start_s;
  logic              last_beat_s;
  logic              line_we_s;
  logic              line_set_s;
  logic              line_clr_s;
  logic              line_valid_s;
  logic [TAGW-1:0]   line_tag_s;
  logic [ILEN-1:0]   slot_instr_s;
  logic              unused_bits_s;

  fetch_line_buf #(
    .BUS_DATA_WIDTH(BUS_DATA_WIDTH),
    .BEATS         (BEATS),
    .ILEN          (ILEN),
    .TAGW          (TAGW),
    .BEAT_W        (BEAT_W),
    .SLOT_W        (SLOT_W)
  ) u_line_buf (
    .clk       (clk),
    .reset     (reset),
    .we        (line_we_s),
    .wbeat     (beat_r),
    .wdata     (fif.bus_resp),
    .set_valid (line_set_s),
    .set_tag   (req_tag_r),
    .clr_valid (line_clr_s),
    .slot      (pc_r[OFFW-1:2]),
    .rdata     (slot_instr_s),
    .line_valid(line_valid_s),
    .line_tag  (line_tag_s)
  );

  assign hit_s         = line_valid_s && (line_tag_s == pc_r[63:OFFW]);
  assign fire_s        = fif.instr_valid && fif.instr_ready;
  assign last_beat_s   = (beat_r == BEAT_W'(BEATS - 1));
  assign miss_start_s  = (state_r == IDLE) && (state_nxt_s == REQ);
  assign unused_bits_s = ^{fif.bus_resptag, redirect_pc[1:0]};

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // A redirect in IDLE postpones the miss decision until the new pc is visible.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!hit_s && !redirect_valid) state_nxt_s = REQ;
        else                           state_nxt_s = IDLE;
      end
      REQ: begin
        if (fif.bus_reqack) state_nxt_s = RESP;
        else                state_nxt_s = REQ;
      end
      RESP: begin
        if (fif.bus_respcyc && last_beat_s) state_nxt_s = IDLE;
        else                                state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs; instr_valid never looks at instr_ready.
  always_comb begin
    fif.instr_valid = 1'b0;
    fif.instr       = '0;
    fif.instr_pc    = 64'd0;
    fif.bus_reqcyc  = 1'b0;
    fif.bus_req     = '0;
    fif.bus_reqtag  = '0;
    fif.bus_respack = 1'b0;
    line_we_s       = 1'b0;
    line_set_s      = 1'b0;
    line_clr_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (hit_s) begin
          fif.instr_valid = !redirect_valid;
          fif.instr       = slot_instr_s;
          fif.instr_pc    = pc_r;
        end else begin
          fif.instr_valid = 1'b0;
        end
      end
      REQ: begin
        fif.bus_reqcyc = 1'b1;
        fif.bus_req    = BUS_DATA_WIDTH'({req_tag_r, {OFFW{1'b0}}});
        fif.bus_reqtag = RD_TAG;
        line_clr_s     = fif.bus_reqack;
      end
      RESP: begin
        fif.bus_respack = fif.bus_respcyc;
        line_we_s       = fif.bus_respcyc;
        line_set_s      = fif.bus_respcyc && last_beat_s;
      end
      default: begin
        fif.instr_valid = 1'b0;
      end
    endcase
  end

  // Architectural fetch PC; redirect has priority over the issue increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= entry;
    end else if (redirect_valid) begin
      pc_r <= {redirect_pc[63:2], 2'b00};
    end else if (fire_s) begin
      pc_r <= pc_r + 64'd4;
    end
  end

  // Refill bookkeeping: requested line tag and beat counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_tag_r <= '0;
      beat_r    <= '0;
    end else begin
      if (miss_start_s) begin
        req_tag_r <= pc_r[63:OFFW];
      end
      if ((state_r == REQ) && fif.bus_reqack) begin
        beat_r <= '0;
      end else if ((state_r == RESP) && fif.bus_respcyc) begin
        beat_r <= beat_r + BEAT_W'(1);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] hits_r;
  logic [31:0] misses_r;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hits_r   <= 32'd0;
      misses_r <= 32'd0;
    end else begin
      if (fire_s && (hits_r != 32'hFFFF_FFFF)) begin
        hits_r <= hits_r + 32'd1;
      end
      if (miss_start_s && (misses_r != 32'hFFFF_FFFF)) begin
        misses_r <= misses_r + 32'd1;
      end
    end
  end

  assign perf_hits   = hits_r;
  assign perf_misses = misses_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a small Sysbus memory responder.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .ILEN(32)) fif ();

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .entry         (entry),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fif           (fif)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_hits     (perf_hits),
    .perf_misses   (perf_misses)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory image: the word at 0x1000+4i holds i.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [31:0] w;
    w = a[31:0];
    return (w >> 2) - 32'h0000_0400;
  endfunction

  task automatic check_issue(input logic [63:0] pc, input logic [31:0] word);
    check_eq("issue_valid", {63'd0, fif.instr_valid}, 64'd1);
    check_eq("issue_pc", fif.instr_pc, pc);
    check_eq("issue_instr", {32'd0, fif.instr}, {32'd0, word});
  endtask

  // Serve one read burst; optionally redirect at a beat and stop after stop_beat beats.
  task automatic serve(input logic [63:0] base, input int ack_delay, input int redir_beat,
                       input logic [63:0] redir_pc, input int stop_beat);
    int n;
    int acks;
    n = 0;
    acks = 0;
    while (!fif.bus_reqcyc && n < 20) begin
      tick();
      n++;
    end
    check_eq("req_seen", {63'd0, fif.bus_reqcyc}, 64'd1);
    check_eq("req_addr", fif.bus_req, base);
    check_eq("req_tag", {51'd0, fif.bus_reqtag}, 64'h1100);
    for (int d = 0; d < ack_delay; d++) begin
      tick();
      check_eq("hold_reqcyc", {63'd0, fif.bus_reqcyc}, 64'd1);
      check_eq("hold_req", fif.bus_req, base);
      check_eq("hold_tag", {51'd0, fif.bus_reqtag}, 64'h1100);
      check_eq("no_early_respack", {63'd0, fif.bus_respack}, 64'd0);
    end
    fif.bus_reqack = 1'b1;
    tick();
    fif.bus_reqack = 1'b0;
    for (int k = 0; k < stop_beat; k++) begin
      fif.bus_respcyc = 1'b1;
      fif.bus_resp    = {word_at(base + 64'(8 * k + 4)), word_at(base + 64'(8 * k))};
      if (k == redir_beat) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_pc;
      end
      #1;
      if (fif.bus_respack) acks++;
      tick();
      fif.bus_respcyc = 1'b0;
      redirect_valid  = 1'b0;
    end
    check_eq("respack_count", 64'(acks), 64'(stop_beat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b0;
    entry            = 64'h1000;
    redirect_valid   = 1'b0;
    redirect_pc      = 64'd0;
    fif.instr_ready  = 1'b1;
    fif.bus_reqack   = 1'b0;
    fif.bus_respcyc  = 1'b0;
    fif.bus_resp     = 64'd0;
    fif.bus_resptag  = 13'd0;
    repeat (3) tick();

    check_eq("rst_instr_valid", {63'd0, fif.instr_valid}, 64'd0);
    check_eq("rst_instr", {32'd0, fif.instr}, 64'd0);
    check_eq("rst_instr_pc", fif.instr_pc, 64'd0);
    check_eq("rst_reqcyc", {63'd0, fif.bus_reqcyc}, 64'd0);
    check_eq("rst_req", fif.bus_req, 64'd0);
    check_eq("rst_reqtag", {51'd0, fif.bus_reqtag}, 64'd0);
    check_eq("rst_respack", {63'd0, fif.bus_respack}, 64'd0);
    reset = 1'b1;

    // Cold start: one refill, then sixteen back-to-back issues, then the next line.
    serve(64'h1000, 0, -1, 64'd0, 8);
    for (int i = 0; i < 16; i++) begin
      #1;
      check_issue(64'h1000 + 64'(4 * i), 32'(i));
      tick();
    end
    #1;
    check_eq("line_end_miss", {63'd0, fif.instr_valid}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_hits_16", {32'd0, perf_hits}, 64'd16);
    check_eq("perf_misses_1", {32'd0, perf_misses}, 64'd1);
`endif
    serve(64'h1040, 0, -1, 64'd0, 8);
    #1;
    check_issue(64'h1040, 32'h10);

    // Redirect back into the first line, forcing a refill of 0x1000.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1008;
    #1;
    check_eq("redir_kill_valid", {63'd0, fif.instr_valid}, 64'd0);
    tick();
    redirect_valid = 1'b0;
    serve(64'h1000, 0, -1, 64'd0, 8);

    // Decoder stall holds the instruction and pc.
    fif.instr_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      check_issue(64'h1008, 32'd2);
      tick();
    end
    fif.instr_ready = 1'b1;
    #1;
    check_issue(64'h1008, 32'd2);
    tick();
    #1;
    check_issue(64'h100C, 32'd3);

    redirect_valid = 1'b1;
    redirect_pc    = 64'h1004;
    #1;
    check_eq("redir2_kill_valid", {63'd0, fif.instr_valid}, 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_issue(64'h1004, 32'd1);

    // Redirect while issuing 0x1004: low bits dropped, hit without bus traffic.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1023;
    #1;
    check_eq("redir3_kill_valid", {63'd0, fif.instr_valid}, 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_issue(64'h1020, 32'd8);
    check_eq("redir_hit_no_req", {63'd0, fif.bus_reqcyc}, 64'd0);
    tick();
    #1;
    check_issue(64'h1024, 32'd9);
    check_eq("redir_hit_no_req2", {63'd0, fif.bus_reqcyc}, 64'd0);

    // Slow ack plus a redirect mid-burst: burst completes, then the new line is fetched.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1080;
    tick();
    redirect_valid = 1'b0;
    serve(64'h1080, 10, 3, 64'h2000, 8);
    #1;
    check_eq("post_burst_miss", {63'd0, fif.instr_valid}, 64'd0);
    serve(64'h2000, 0, -1, 64'd0, 8);
    #1;
    check_issue(64'h2000, 32'h400);

    // Reset in the middle of a burst.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2040;
    tick();
    redirect_valid = 1'b0;
    serve(64'h2040, 0, -1, 64'd0, 4);
    fif.bus_respcyc = 1'b1;
    fif.bus_resp    = {word_at(64'h2064), word_at(64'h2060)};
    #1;
    check_eq("beat4_respack", {63'd0, fif.bus_respack}, 64'd1);
    entry = 64'h3000;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_instr_valid", {63'd0, fif.instr_valid}, 64'd0);
    check_eq("mid_rst_instr", {32'd0, fif.instr}, 64'd0);
    check_eq("mid_rst_instr_pc", fif.instr_pc, 64'd0);
    check_eq("mid_rst_reqcyc", {63'd0, fif.bus_reqcyc}, 64'd0);
    check_eq("mid_rst_req", fif.bus_req, 64'd0);
    check_eq("mid_rst_reqtag", {51'd0, fif.bus_reqtag}, 64'd0);
    check_eq("mid_rst_respack", {63'd0, fif.bus_respack}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("mid_rst_perf_hits", {32'd0, perf_hits}, 64'd0);
    check_eq("mid_rst_perf_misses", {32'd0, perf_misses}, 64'd0);
`endif
    tick();
    tick();
    fif.bus_respcyc = 1'b0;
    reset = 1'b1;
    serve(64'h3000, 0, -1, 64'd0, 8);
    #1;
    check_issue(64'h3000, 32'h800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
